// File: rtl/stopwatch_seq.sv
// Stopwatch run/pause/lap/clear sequencer.
// Divides clk into a periodic count tick that drives the LSD counter's up
// enable. It also drives the chain clear and the display lap-hold from two
// debounced button pulses, and watches the chain terminal count for
// overflow. Every output is a flop, so no input reaches an output
// combinationally.
module stopwatch_seq #(
  parameter int unsigned TICK_DIV   = 270000,
  parameter bit          SAT_ON_OVF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       chain_tc,
  output logic       cnt_up,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic       running,
  output logic       ovf,
  output logic [1:0] state
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] LAP   = 2'b11;

  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nxt_s;
  logic [1:0]    state_nxt_s;
  logic          counting_s;
  logic          tick_s;
  logic          ovf_hit_s;
  logic          sat_stop_s;
  logic          clr_exit_s;
  logic          cnt_up_nxt_s;
  logic          ovf_nxt_s;

  // Tick and overflow detection from the current state and prescaler
  always_comb begin
    counting_s = (state == RUN) || (state == LAP);
    tick_s     = counting_s && (presc_r == PRESC_MAX);
    ovf_hit_s  = tick_s && chain_tc;
    sat_stop_s = SAT_ON_OVF && ovf_hit_s;
  end

  // FSM next state; a saturating overflow outranks both buttons, and
  // start/stop outranks lap/reset
  always_comb begin
    state_nxt_s = state;
    case (state)
      IDLE: begin
        if (btn_ss) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (sat_stop_s || btn_ss) begin
          state_nxt_s = PAUSE;
        end else if (btn_lr) begin
          state_nxt_s = LAP;
        end else begin
          state_nxt_s = RUN;
        end
      end
      LAP: begin
        if (sat_stop_s || btn_ss) begin
          state_nxt_s = PAUSE;
        end else if (btn_lr) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = LAP;
        end
      end
      PAUSE: begin
        // after an overflow only lap/reset may leave PAUSE
        if (btn_ss && !ovf) begin
          state_nxt_s = RUN;
        end else if (btn_lr) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PAUSE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Prescaler, tick pulse, overflow flag and clear-pulse next values
  always_comb begin
    presc_nxt_s  = presc_r;
    clr_exit_s   = (state == PAUSE) && (state_nxt_s == IDLE);
    cnt_up_nxt_s = tick_s && !sat_stop_s;
    ovf_nxt_s    = ovf;

    if (counting_s) begin
      // a tick always wraps, even when a stop lands on the same cycle
      if (tick_s) begin
        presc_nxt_s = PRESC_ZERO;
      end else begin
        presc_nxt_s = presc_r + PRESC_ONE;
      end
    end else if ((state == IDLE) || clr_exit_s) begin
      presc_nxt_s = PRESC_ZERO;
    end else begin
      presc_nxt_s = presc_r;
    end

    if (clr_exit_s) begin
      ovf_nxt_s = 1'b0;
    end else if (ovf_hit_s) begin
      ovf_nxt_s = 1'b1;
    end else begin
      ovf_nxt_s = ovf;
    end
  end

  // State, prescaler and all outputs registered; reset clears the chain
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc_r  <= PRESC_ZERO;
      cnt_up   <= 1'b0;
      cnt_clr  <= 1'b1;
      lap_hold <= 1'b0;
      running  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt_s;
      presc_r  <= presc_nxt_s;
      cnt_up   <= cnt_up_nxt_s;
      cnt_clr  <= clr_exit_s;
      lap_hold <= (state_nxt_s == LAP);
      running  <= (state_nxt_s == RUN) || (state_nxt_s == LAP);
      ovf      <= ovf_nxt_s;
    end
  end

endmodule

// File: tb/tb_stopwatch_seq.sv
// Directed bench for stopwatch_seq with TICK_DIV=4.
// One instance saturates on overflow and one wraps. Both share the clock,
// reset and buttons, and each has its own chain_tc.
module tb_stopwatch_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       tc_sat = 1'b0;
  logic       tc_wrap = 1'b0;

  logic       up_s, clr_s, hold_s, run_s, ovf_s;
  logic [1:0] st_s;
  logic       up_w, clr_w, hold_w, run_w, ovf_w;
  logic [1:0] st_w;

  int total = 0;
  int bad = 0;

  stopwatch_seq #(.TICK_DIV(4), .SAT_ON_OVF(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr), .chain_tc(tc_sat),
    .cnt_up(up_s), .cnt_clr(clr_s), .lap_hold(hold_s), .running(run_s),
    .ovf(ovf_s), .state(st_s)
  );

  stopwatch_seq #(.TICK_DIV(4), .SAT_ON_OVF(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr), .chain_tc(tc_wrap),
    .cnt_up(up_w), .cnt_clr(clr_w), .lap_hold(hold_w), .running(run_w),
    .ovf(ovf_w), .state(st_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_ss();
    btn_ss = 1'b1;
    cyc(1);
    btn_ss = 1'b0;
  endtask

  task automatic press_lr();
    btn_lr = 1'b1;
    cyc(1);
    btn_lr = 1'b0;
  endtask

  initial begin
    // 1: reset values, start, tick period 4
    cyc(2);
    check("rst_clr", clr_s, 1);
    check("rst_state", st_s, 0);
    check("rst_up", up_s, 0);
    check("rst_hold", hold_s, 0);
    check("rst_run", run_s, 0);
    check("rst_ovf", ovf_s, 0);
    rst = 1'b0;
    cyc(1);
    check("clr_release", clr_s, 0);
    cyc(1);
    press_ss();
    check("start_state", st_s, 1);
    check("start_run", run_s, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      check("t1_up", up_s, (i % 4 == 0) ? 1 : 0);
    end

    // 2: pause freezes the prescaler at 2, resume ticks after 2 cycles
    cyc(1);
    press_ss();
    check("pause_state", st_s, 2);
    check("pause_run", run_s, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check("pause_up", up_s, 0);
    end
    press_ss();
    check("resume_state", st_s, 1);
    check("resume_up0", up_s, 0);
    cyc(1);
    check("resume_up1", up_s, 0);
    cyc(1);
    check("resume_up2", up_s, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      check("t2_up", up_s, (i == 4) ? 1 : 0);
    end

    // 3: lap keeps counting, second lap returns to RUN
    press_lr();
    check("lap_state", st_s, 3);
    check("lap_hold", hold_s, 1);
    check("lap_run", run_s, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      check("lap_up", up_s, (i == 3) ? 1 : 0);
    end
    press_lr();
    check("unlap_state", st_s, 1);
    check("unlap_hold", hold_s, 0);
    cyc(1);
    check("unlap_up1", up_s, 0);
    cyc(1);
    check("unlap_up2", up_s, 1);

    // 4: PAUSE -> IDLE clears, both buttons in IDLE start a run
    press_ss();
    check("p4_state", st_s, 2);
    press_lr();
    check("clear_state", st_s, 0);
    check("clear_pulse", clr_s, 1);
    check("clear_ovf", ovf_s, 0);
    cyc(1);
    check("clear_drop", clr_s, 0);
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    cyc(1);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    check("both_idle_state", st_s, 1);
    check("both_idle_hold", hold_s, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      check("p4_up", up_s, (i == 4) ? 1 : 0);
    end
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    cyc(1);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    check("both_run_state", st_s, 2);
    check("both_run_hold", hold_s, 0);
    press_lr();
    cyc(1);

    // 5: saturating overflow
    tc_sat = 1'b1;
    press_ss();
    cyc(3);
    check("ovf_pre_state", st_s, 1);
    check("ovf_pre_flag", ovf_s, 0);
    cyc(1);
    check("ovf_up", up_s, 0);
    check("ovf_state", st_s, 2);
    check("ovf_flag", ovf_s, 1);
    check("ovf_run", run_s, 0);
    press_ss();
    check("ovf_ss_ignored", st_s, 2);
    cyc(3);
    check("ovf_no_up", up_s, 0);
    press_lr();
    check("ovf_exit_state", st_s, 0);
    check("ovf_exit_flag", ovf_s, 0);
    check("ovf_exit_clr", clr_s, 1);
    tc_sat = 1'b0;
    cyc(1);

    // 6a: reset in LAP on a tick cycle
    press_ss();
    cyc(1);
    press_lr();
    check("p6_lap", st_s, 3);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check("midrst_up", up_s, 0);
    check("midrst_state", st_s, 0);
    check("midrst_clr", clr_s, 1);
    check("midrst_hold", hold_s, 0);
    check("midrst_run", run_s, 0);
    check("midrst_ovf", ovf_s, 0);
    rst = 1'b0;
    cyc(1);

    // 6b: wrapping overflow passes the tick and sets the sticky flag
    tc_wrap = 1'b1;
    press_ss();
    check("wrap_start", st_w, 1);
    cyc(3);
    check("wrap_pre_up", up_w, 0);
    cyc(1);
    check("wrap_up", up_w, 1);
    check("wrap_ovf", ovf_w, 1);
    check("wrap_state", st_w, 1);
    tc_wrap = 1'b0;
    cyc(1);
    check("wrap_state2", st_w, 1);
    check("wrap_ovf_sticky", ovf_w, 1);
    check("wrap_up_drop", up_w, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
